// File: rtl/dip_scan_controller_pkg.sv
// rtl/dip_scan_controller_pkg.sv - shared constants for the DIP shift-chain scanner
package dip_scan_controller_pkg;

    localparam int DIP_WIDTH = 16;

    // Scan FSM encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_SLOW  = 3'd2;
    localparam logic [2:0] ST_SHIGH = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Chain control levels while no scan is running
    localparam logic PL_N_IDLE = 1'b1;
    localparam logic SCK_IDLE  = 1'b0;

endpackage

// File: rtl/dip_scan_debounce.sv
// rtl/dip_scan_debounce.sv - multi-scan debounce and publish of the raw switch word
module dip_scan_debounce
    import dip_scan_controller_pkg::*;
#(
    parameter int WIDTH      = DIP_WIDTH,
    parameter int STABLE_CNT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             done,
    input  logic [WIDTH-1:0] raw,
    input  logic             ack,
    output logic [WIDTH-1:0] word,
    output logic             latch,
    output logic             pending
);

    localparam int SW = $clog2(STABLE_CNT + 1);

    logic [WIDTH-1:0] prev_raw;
    logic [SW-1:0]    stable;
    logic [SW-1:0]    stable_next;
    logic             publish;

    always_comb begin
        stable_next = SW'(1);
        if (raw == prev_raw) begin
            stable_next = (stable >= SW'(STABLE_CNT)) ? SW'(STABLE_CNT) : stable + 1'b1;
        end
        publish = done && (stable_next >= SW'(STABLE_CNT)) && (raw != word);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_raw <= '0;
            stable   <= '0;
            word     <= '0;
            latch    <= 1'b0;
            pending  <= 1'b0;
        end else begin
            if (done) begin
                prev_raw <= raw;
                stable   <= stable_next;
            end
            if (publish) begin
                word <= raw;
            end
            latch <= publish;
            // An acknowledge coinciding with a new publish must not lose it
            if (publish || latch) begin
                pending <= 1'b1;
            end else if (ack) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dip_scan_controller.sv
// rtl/dip_scan_controller.sv - periodic PISO DIP chain scan, deserialise and debounce
module dip_scan_controller
    import dip_scan_controller_pkg::*;
#(
    parameter int WIDTH      = DIP_WIDTH,
    parameter int SCAN_DIV   = 1000,
    parameter int SCK_HALF   = 2,
    parameter int STABLE_CNT = 3
) (
    input  logic             i_CLK,
    input  logic             i_RESET,
    input  logic             i_Enable,
    input  logic             i_SerData,
    input  logic             i_Ack,
    output logic             o_PL_n,
    output logic             o_SCK,
    output logic [WIDTH-1:0] o_DIP16,
    output logic             o_DIPLatch,
    output logic             o_Pending,
    output logic             o_ScanDone
);

    localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int PW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [TW-1:0]    tick_ctr;
    logic             tick;
    logic [2:0]       state;
    logic [PW-1:0]    phase;
    logic             phase_end;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    bit_pos;
    logic [WIDTH-1:0] shift_reg;

    assign tick      = (tick_ctr == TW'(SCAN_DIV - 1));
    assign phase_end = (phase == PW'(SCK_HALF - 1));
    assign bit_pos   = IW'(WIDTH - 1) - idx;

    always_ff @(posedge i_CLK or negedge i_RESET) begin
        if (!i_RESET) begin
            tick_ctr   <= '0;
            state      <= ST_IDLE;
            phase      <= '0;
            idx        <= '0;
            shift_reg  <= '0;
            o_PL_n     <= PL_N_IDLE;
            o_SCK      <= SCK_IDLE;
            o_ScanDone <= 1'b0;
        end else begin
            tick_ctr   <= tick ? '0 : tick_ctr + 1'b1;
            o_ScanDone <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tick && i_Enable) begin
                        state  <= ST_LOAD;
                        phase  <= '0;
                        idx    <= '0;
                        o_PL_n <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (phase_end) begin
                        state  <= ST_SLOW;
                        phase  <= '0;
                        o_PL_n <= PL_N_IDLE;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                ST_SLOW: begin
                    // Chain already presents the current bit, so sample before rising SCK
                    if (phase_end) begin
                        shift_reg[bit_pos] <= i_SerData;
                        phase              <= '0;
                        if (idx == IW'(WIDTH - 1)) begin
                            state      <= ST_DONE;
                            o_ScanDone <= 1'b1;
                        end else begin
                            state <= ST_SHIGH;
                            o_SCK <= 1'b1;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                ST_SHIGH: begin
                    if (phase_end) begin
                        state <= ST_SLOW;
                        phase <= '0;
                        idx   <= idx + 1'b1;
                        o_SCK <= SCK_IDLE;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state  <= ST_IDLE;
                    o_PL_n <= PL_N_IDLE;
                    o_SCK  <= SCK_IDLE;
                end
            endcase
        end
    end

    dip_scan_debounce #(
        .WIDTH      (WIDTH),
        .STABLE_CNT (STABLE_CNT)
    ) u_debounce (
        .clk     (i_CLK),
        .rst_n   (i_RESET),
        .done    (o_ScanDone),
        .raw     (shift_reg),
        .ack     (i_Ack),
        .word    (o_DIP16),
        .latch   (o_DIPLatch),
        .pending (o_Pending)
    );

endmodule

// File: tb/tb_dip_scan_controller.sv
// tb/tb_dip_scan_controller.sv - directed bench with a PISO chain model
module tb_dip_scan_controller;

    localparam int DIV = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        ser;
    logic        ack = 1'b0;
    logic        pl_n;
    logic        sck;
    logic [15:0] dip;
    logic        latch;
    logic        pending;
    logic        done;

    logic [15:0] switches = 16'h0000;
    logic [15:0] chain = 16'h0000;

    int total = 0;
    int passed = 0;
    int cyc = 0;
    int pl_cnt = 0;
    int sck_cnt = 0;
    int pl_falls = 0;
    int fall_cyc = 0;
    int latch_cnt = 0;
    logic prev_pl = 1'b1;
    logic prev_sck = 1'b0;

    dip_scan_controller #(
        .WIDTH(16), .SCAN_DIV(DIV), .SCK_HALF(2), .STABLE_CNT(3)
    ) dut (
        .i_CLK      (clk),
        .i_RESET    (rst_n),
        .i_Enable   (en),
        .i_SerData  (ser),
        .i_Ack      (ack),
        .o_PL_n     (pl_n),
        .o_SCK      (sck),
        .o_DIP16    (dip),
        .o_DIPLatch (latch),
        .o_Pending  (pending),
        .o_ScanDone (done)
    );

    always #5 clk = ~clk;

    always @(posedge sck or negedge pl_n) begin
        if (!pl_n) chain = switches;
        else       chain = {chain[14:0], 1'b0};
    end
    assign ser = chain[15];

    always @(negedge clk) begin
        cyc++;
        if (prev_pl && !pl_n) begin
            pl_falls++;
            fall_cyc = cyc;
            sck_cnt  = 0;
            pl_cnt   = 0;
        end
        if (!pl_n) pl_cnt++;
        if (!prev_sck && sck) sck_cnt++;
        if (latch) latch_cnt++;
        prev_pl  = pl_n;
        prev_sck = sck;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Waits for the DONE cycle, then advances to the cycle where a publish would show
    task automatic do_scan(input string tag);
        int n = 0;
        while (!done && n < 2 * DIV + 100) begin
            step();
            n++;
        end
        check({tag, "_done_seen"}, done, 1'b1);
        check({tag, "_pl_low_cycles"}, pl_cnt, 2);
        check({tag, "_sck_pulses"}, sck_cnt, 15);
        step();
        check({tag, "_done_one_cycle"}, done, 1'b0);
    endtask

    initial begin
        int lc;
        int f0;
        int t0;
        int en_cyc;
        int n;

        // 1: reset state, then first publish after three identical scans
        step();
        step();
        check("rst_pl_n", pl_n, 1'b1);
        check("rst_sck", sck, 1'b0);
        check("rst_dip", dip, 16'h0000);
        check("rst_latch", latch, 1'b0);
        check("rst_pending", pending, 1'b0);
        check("rst_done", done, 1'b0);
        switches = 16'h8648;
        rst_n = 1'b1;
        en = 1'b1;
        do_scan("t1_s1");
        check("t1_s1_dip", dip, 16'h0000);
        do_scan("t1_s2");
        check("t1_s2_dip", dip, 16'h0000);
        check("t1_s2_latch", latch, 1'b0);
        do_scan("t1_s3");
        check("t1_s3_dip", dip, 16'h8648);
        check("t1_s3_latch", latch, 1'b1);
        check("t1_s3_pending", pending, 1'b1);
        step();
        check("t1_latch_one_cycle", latch, 1'b0);
        check("t1_latch_count", latch_cnt, 1);

        // 2: bouncing input holds the word; then a stable run publishes
        switches = 16'h00FF; do_scan("t2_b1");
        switches = 16'h0F0F; do_scan("t2_b2");
        switches = 16'h00FF; do_scan("t2_b3");
        check("t2_bounce_dip", dip, 16'h8648);
        check("t2_bounce_latch_count", latch_cnt, 1);
        switches = 16'h0F0F;
        do_scan("t2_h1");
        do_scan("t2_h2");
        check("t2_h2_dip", dip, 16'h8648);
        do_scan("t2_h3");
        check("t2_h3_dip", dip, 16'h0F0F);
        check("t2_h3_latch", latch, 1'b1);

        // 3: re-stable same word does not re-latch; ack clears; ack during latch keeps pending
        do_scan("t3_same");
        step();
        check("t3_latch_count", latch_cnt, 2);
        check("t3_pending_sticky", pending, 1'b1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        step();
        check("t3_pending_acked", pending, 1'b0);
        switches = 16'h8648;
        do_scan("t3_p1");
        do_scan("t3_p2");
        do_scan("t3_p3");
        check("t3_p3_latch", latch, 1'b1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("t3_pending_ack_with_latch", pending, 1'b1);

        // 4: disable mid-scan, scan still completes, no new start, restart on a tick
        switches = 16'h1234;
        f0 = pl_falls;
        n = 0;
        while (pl_falls == f0 && n < 2 * DIV + 10) begin step(); n++; end
        check("t4_scan_started", (pl_falls != f0), 1'b1);
        t0 = fall_cyc;
        repeat (10) step();
        en = 1'b0;
        do_scan("t4_last");
        f0 = pl_falls;
        repeat (2 * DIV + 10) step();
        check("t4_no_new_load", pl_falls, f0);
        en = 1'b1;
        en_cyc = cyc;
        n = 0;
        while (pl_falls == f0 && n < 2 * DIV + 10) begin step(); n++; end
        check("t4_restart_seen", (pl_falls != f0), 1'b1);
        check("t4_restart_on_tick", (fall_cyc - t0) % DIV, 0);
        check("t4_not_immediate", (fall_cyc - en_cyc) > 1, 1'b1);

        // 5: reset while SCK is high for bit 7
        n = 0;
        while (sck_cnt != 8 && n < 2 * DIV) begin step(); n++; end
        check("t5_at_bit7_high", sck, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_sck", sck, 1'b0);
        check("t5_rst_pl_n", pl_n, 1'b1);
        check("t5_rst_dip", dip, 16'h0000);
        check("t5_rst_pending", pending, 1'b0);
        repeat (3) step();
        rst_n = 1'b1;
        lc = latch_cnt;
        do_scan("t5_s1");
        check("t5_s1_dip", dip, 16'h0000);
        do_scan("t5_s2");
        check("t5_s2_dip", dip, 16'h0000);
        do_scan("t5_s3");
        check("t5_s3_dip", dip, 16'h1234);
        check("t5_latch_count", latch_cnt, lc + 1);

        // 6: bit ordering with all-ones then only the LSB set
        switches = 16'hFFFF;
        do_scan("t6_f1"); do_scan("t6_f2"); do_scan("t6_f3");
        check("t6_ffff", dip, 16'hFFFF);
        switches = 16'h0001;
        do_scan("t6_o1"); do_scan("t6_o2");
        check("t6_hold_ffff", dip, 16'hFFFF);
        do_scan("t6_o3");
        check("t6_0001", dip, 16'h0001);
        check("t6_latch", latch, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
